// File: rtl/serial_nibble_adder.sv
// serial_nibble_adder: adds two wide operands one nibble per clock through an
// external four_bit_full_adder, least-significant nibble first, carrying the
// adder's cout between nibbles and publishing a registered sum and carry-out.
module serial_nibble_adder #(
   parameter int NUM_NIBBLES = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic [4*NUM_NIBBLES-1:0]   a_i,
   input  logic [4*NUM_NIBBLES-1:0]   b_i,
   input  logic                       cin_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [4*NUM_NIBBLES-1:0]   sum_o,
   output logic                       cout_o,
   output logic [3:0]                 add_a_o,
   output logic [3:0]                 add_b_o,
   output logic                       add_cin_o,
   input  logic [3:0]                 add_sum_i,
   input  logic                       add_cout_i
);

   localparam int W  = 4 * NUM_NIBBLES;
   localparam int CW = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

   stateT           r_state;
   stateT           w_stateNext;
   logic [W-1:0]    r_opA;
   logic [W-1:0]    r_opB;
   logic [W-1:0]    r_result;
   logic            r_carry;
   logic [CW-1:0]   r_count;
   logic [W-1:0]    r_sum;
   logic            r_cout;
   logic [W-1:0]    w_resultNext;
   logic            w_lastNibble;

   // The adder's sum nibble enters at the top; after NUM_NIBBLES shifts the
   // first nibble computed has reached the bottom of the result register.
   assign w_resultNext = W'({add_sum_i, r_result} >> 4);
   assign w_lastNibble = (r_count == CW'(NUM_NIBBLES - 1));

   assign sum_o  = r_sum;
   assign cout_o = r_cout;

   // State register; reset abandons any operation in flight immediately.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state and output decode; adder inputs are only driven while running.
   always_comb begin
      w_stateNext = r_state;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      add_a_o     = 4'd0;
      add_b_o     = 4'd0;
      add_cin_o   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_i) begin
               w_stateNext = RUN;
            end
         end
         RUN: begin
            busy_o    = 1'b1;
            add_a_o   = r_opA[3:0];
            add_b_o   = r_opB[3:0];
            add_cin_o = r_carry;
            if (w_lastNibble) begin
               w_stateNext = DONE;
            end
         end
         DONE: begin
            done_o      = 1'b1;
            w_stateNext = start_i ? RUN : IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // Operand/result shifting, carry hand-off and result publication at the last nibble.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_opA    <= '0;
         r_opB    <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_count  <= '0;
         r_sum    <= '0;
         r_cout   <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start_i) begin
                  r_opA   <= a_i;
                  r_opB   <= b_i;
                  r_carry <= cin_i;
                  r_count <= '0;
               end
            end
            RUN: begin
               r_result <= w_resultNext;
               r_carry  <= add_cout_i;
               r_opA    <= r_opA >> 4;
               r_opB    <= r_opB >> 4;
               r_count  <= r_count + CW'(1);
               if (w_lastNibble) begin
                  r_sum  <= w_resultNext;
                  r_cout <= add_cout_i;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_nibble_adder.sv
// tb_serial_nibble_adder: drives a 4-nibble and a 1-nibble instance, each
// paired with a behavioural four-bit adder, and compares against plain
// arithmetic on the whole operands.
module tb_serial_nibble_adder;

   logic        clk = 1'b0;
   logic        rst;

   logic        startA;
   logic [15:0] aA, bA;
   logic        cinA;
   logic        busyA, doneA, coutA;
   logic [15:0] sumA;
   logic [3:0]  addAA, addBA, addSumA;
   logic        addCinA, addCoutA;

   logic        startB;
   logic [3:0]  aB, bB;
   logic        cinB;
   logic        busyB, doneB, coutB;
   logic [3:0]  sumB;
   logic [3:0]  addAB, addBB, addSumB;
   logic        addCinB, addCoutB;

   int nCompared    = 0;
   int nMismatched  = 0;
   int cycleNo      = 0;
   int doneCountA   = 0;
   int overlapCount = 0;

   serial_nibble_adder #(.NUM_NIBBLES(4)) dutA (
      .clk_i(clk), .rst_i(rst), .start_i(startA), .a_i(aA), .b_i(bA), .cin_i(cinA),
      .busy_o(busyA), .done_o(doneA), .sum_o(sumA), .cout_o(coutA),
      .add_a_o(addAA), .add_b_o(addBA), .add_cin_o(addCinA),
      .add_sum_i(addSumA), .add_cout_i(addCoutA)
   );

   serial_nibble_adder #(.NUM_NIBBLES(1)) dutB (
      .clk_i(clk), .rst_i(rst), .start_i(startB), .a_i(aB), .b_i(bB), .cin_i(cinB),
      .busy_o(busyB), .done_o(doneB), .sum_o(sumB), .cout_o(coutB),
      .add_a_o(addAB), .add_b_o(addBB), .add_cin_o(addCinB),
      .add_sum_i(addSumB), .add_cout_i(addCoutB)
   );

   // Behavioural stand-ins for the external four_bit_full_adder instances.
   assign {addCoutA, addSumA} = 5'(addAA) + 5'(addBA) + 5'(addCinA);
   assign {addCoutB, addSumB} = 5'(addAB) + 5'(addBB) + 5'(addCinB);

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Count completion pulses and any cycle where busy and done coincide.
   always @(negedge clk) begin
      if (doneA) doneCountA++;
      if ((busyA && doneA) || (busyB && doneB)) overlapCount++;
   end

   function automatic logic [16:0] refAdd(input logic [15:0] a, input logic [15:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + 17'(c);
   endfunction

   // Carry entering nibble i is bit 4i of the sum of the operands' low 4i bits plus cin.
   function automatic logic refCarryInto(input logic [15:0] a, input logic [15:0] b, input logic c, input int i);
      int unsigned m, lo;
      if (i == 0) return c;
      m  = (32'd1 << (4 * i)) - 32'd1;
      lo = (32'(a) & m) + (32'(b) & m) + 32'(c);
      return 1'((lo >> (4 * i)) & 32'd1);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cycleNo++;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic c);
      startA = 1'b1;
      aA     = a;
      bA     = b;
      cinA   = c;
   endtask

   // One complete operation on the 4-nibble instance, checking every adder drive and the result.
   task automatic runOpA(input logic [15:0] a, input logic [15:0] b, input logic c, input string tag);
      logic [16:0] expected;
      int          n;
      expected = refAdd(a, b, c);
      applyStimulus(a, b, c);
      tick();
      startA = 1'b0;
      aA     = 16'($urandom);
      bA     = 16'($urandom);
      cinA   = 1'($urandom);
      n = 0;
      while (busyA && n < 20) begin
         if (n < 4) begin
            checkOutput($sformatf("%s_addA%0d", tag, n), addAA, 4'(a >> (4 * n)));
            checkOutput($sformatf("%s_addB%0d", tag, n), addBA, 4'(b >> (4 * n)));
            checkOutput($sformatf("%s_addCin%0d", tag, n), addCinA, refCarryInto(a, b, c, n));
         end
         tick();
         n++;
      end
      checkOutput({tag, "_busyLen"}, n, 4);
      checkOutput({tag, "_done"}, doneA, 1'b1);
      checkOutput({tag, "_sum"}, sumA, expected[15:0]);
      checkOutput({tag, "_cout"}, coutA, expected[16]);
      tick();
      checkOutput({tag, "_doneEnd"}, doneA, 1'b0);
      checkOutput({tag, "_sumHold"}, sumA, expected[15:0]);
   endtask

   // One operation on the single-nibble instance: one RUN cycle then DONE.
   task automatic runOpB(input logic [3:0] a, input logic [3:0] b, input logic c, input string tag);
      logic [4:0] expected;
      expected = 5'(a) + 5'(b) + 5'(c);
      startB = 1'b1;
      aB = a;
      bB = b;
      cinB = c;
      tick();
      startB = 1'b0;
      checkOutput({tag, "_busy"}, busyB, 1'b1);
      checkOutput({tag, "_addA"}, addAB, a);
      checkOutput({tag, "_addCin"}, addCinB, c);
      tick();
      checkOutput({tag, "_done"}, doneB, 1'b1);
      checkOutput({tag, "_sum"}, sumB, expected[3:0]);
      checkOutput({tag, "_cout"}, coutB, expected[4]);
      tick();
      checkOutput({tag, "_doneEnd"}, doneB, 1'b0);
   endtask

   // Directed scenarios, then randomized operations, then the summary.
   initial begin
      logic [16:0] exp1, exp2;
      int          n, t1, dc0;
      logic [15:0] ra, rb;
      logic        rc;

      rst = 1'b1;
      startA = 1'b0; aA = '0; bA = '0; cinA = 1'b0;
      startB = 1'b0; aB = '0; bB = '0; cinB = 1'b0;
      #12;
      checkOutput("rst_busyA", busyA, 1'b0);
      checkOutput("rst_doneA", doneA, 1'b0);
      checkOutput("rst_sumA", sumA, 16'h0);
      checkOutput("rst_coutA", coutA, 1'b0);
      checkOutput("rst_addA", {addAA, addBA, addCinA}, 9'h0);
      checkOutput("rst_dutB", {busyB, doneB, sumB, coutB}, 7'h0);
      rst = 1'b0;
      tick();

      runOpA(16'h1234, 16'h4321, 1'b0, "basic");
      runOpA(16'hFFFF, 16'h0001, 1'b0, "ripple");
      runOpA(16'hFFFF, 16'hFFFF, 1'b1, "allOnes");
      runOpA(16'h8000, 16'h8000, 1'b0, "msbCarry");

      // A start pulse in the second RUN cycle must be ignored.
      dc0 = doneCountA;
      applyStimulus(16'h0F0F, 16'h0101, 1'b0);
      tick();
      startA = 1'b0;
      tick();
      startA = 1'b1;
      aA = 16'h1111;
      tick();
      startA = 1'b0;
      n = 0;
      while (!doneA && n < 20) begin tick(); n++; end
      checkOutput("restart_sum", sumA, 16'h1010);
      checkOutput("restart_cout", coutA, 1'b0);
      repeat (8) tick();
      checkOutput("restart_donePulses", doneCountA - dc0, 1);

      // start held high: the second pair is sampled in the DONE cycle.
      exp1 = refAdd(16'hA5A5, 16'h1234, 1'b1);
      exp2 = refAdd(16'h7777, 16'h9999, 1'b0);
      applyStimulus(16'hA5A5, 16'h1234, 1'b1);
      tick();
      aA = 16'h7777; bA = 16'h9999; cinA = 1'b0;
      n = 0;
      while (!doneA && n < 20) begin tick(); n++; end
      t1 = cycleNo;
      checkOutput("b2b_done1", doneA, 1'b1);
      checkOutput("b2b_sum1", {coutA, sumA}, exp1);
      tick();
      n = 0;
      while (busyA && n < 20) begin
         checkOutput($sformatf("b2b_hold%0d", n), {coutA, sumA}, exp1);
         tick();
         n++;
      end
      startA = 1'b0;
      checkOutput("b2b_done2", doneA, 1'b1);
      checkOutput("b2b_spacing", cycleNo - t1, 5);
      checkOutput("b2b_sum2", {coutA, sumA}, exp2);
      tick();
      checkOutput("b2b_idle", doneA, 1'b0);

      // Asynchronous reset between edges during the third nibble.
      applyStimulus(16'h1357, 16'h2468, 1'b0);
      tick();
      startA = 1'b0;
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      dc0 = doneCountA;
      checkOutput("midRst_busy", busyA, 1'b0);
      checkOutput("midRst_done", doneA, 1'b0);
      checkOutput("midRst_sum", sumA, 16'h0);
      checkOutput("midRst_cout", coutA, 1'b0);
      checkOutput("midRst_add", {addAA, addBA, addCinA}, 9'h0);
      #1 rst = 1'b0;
      repeat (6) tick();
      checkOutput("midRst_noDone", doneCountA - dc0, 0);
      checkOutput("midRst_sumStay", sumA, 16'h0);
      runOpA(16'h0001, 16'h0001, 1'b0, "postRst");

      // Single-nibble instance.
      runOpB(4'h9, 4'h8, 1'b0, "one");

      // Randomized operations against the arithmetic reference.
      for (int i = 0; i < 8; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         runOpA(ra, rb, rc, $sformatf("randA%0d", i));
      end
      for (int i = 0; i < 6; i++) begin
         runOpB(4'($urandom), 4'($urandom), 1'($urandom), $sformatf("randB%0d", i));
      end

      checkOutput("busyDoneOverlap", overlapCount, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
